// File: rtl/pad_pkg.sv
// pad_pkg: poller FSM state type and standard NES/SNES button bit positions.
package pad_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, PHI, PLO, DONE} pad_state_e;
    localparam int NES_BITS = 8;
    localparam int SNES_BITS = 16;
    localparam int NES_A = 0;
    localparam int NES_B = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START = 3;
    localparam int NES_UP = 4;
    localparam int NES_DOWN = 5;
    localparam int NES_LEFT = 6;
    localparam int NES_RIGHT = 7;
    localparam int SNES_B = 0;
    localparam int SNES_Y = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START = 3;
    localparam int SNES_UP = 4;
    localparam int SNES_DOWN = 5;
    localparam int SNES_LEFT = 6;
    localparam int SNES_RIGHT = 7;
    localparam int SNES_A = 8;
    localparam int SNES_X = 9;
    localparam int SNES_L = 10;
    localparam int SNES_R = 11;
endpackage

// File: rtl/serial_pad_phy.sv
// serial_pad_phy: latch/pulse sequencer sampling one serial line per pad into a raw frame.
module serial_pad_phy
    import pad_pkg::*;
#(
    parameter int BITS = 8,
    parameter int CHANNELS = 2,
    parameter int CLK_DIV = 300
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CHANNELS-1:0]      data_in,
    output logic                     idle,
    output logic                     latch,
    output logic                     pulse,
    output logic                     busy,
    output logic                     done,
    output logic [CHANNELS*BITS-1:0] frame
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(BITS);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL = CW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] LAST = BW'(BITS - 1);
    pad_state_e state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic sample;
    assign idle = state == IDLE;
    // bit 0 is valid at the end of the latch; later bits at the end of each pulse high phase
    assign sample = (state == LATCH && cnt == FULL) || (state == PHI && cnt == HALF);
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            latch   <= 1'b0;
            pulse   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            frame   <= '0;
        end else begin
            done <= 1'b0;
            cnt  <= cnt + 1'b1;
            for (int c = 0; c < CHANNELS; c++)
                if (sample) frame[c*BITS + int'(bit_idx)] <= data_in[c];
            case (state)
                IDLE: if (start) begin
                    state   <= LATCH;
                    latch   <= 1'b1;
                    busy    <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                LATCH: if (cnt == FULL) begin
                    state   <= PHI;
                    latch   <= 1'b0;
                    pulse   <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= BW'(1);
                end
                PHI: if (cnt == HALF) begin
                    state <= PLO;
                    pulse <= 1'b0;
                    cnt   <= '0;
                end
                PLO: if (cnt == HALF) begin
                    cnt <= '0;
                    if (bit_idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= PHI;
                        pulse   <= 1'b1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/serial_pad_poller.sv
// serial_pad_poller: game pad poller with periodic/on-demand polling, held buttons and edge masks.
module serial_pad_poller
    import pad_pkg::*;
#(
    parameter int BITS = 8,
    parameter int CHANNELS = 2,
    parameter int CLK_DIV = 300,
    parameter int POLL_PERIOD = 833333,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      data_in,
    input  logic                     poll_req,
    input  logic                     auto_en,
    output logic                     latch,
    output logic                     pulse,
    output logic                     busy,
    output logic [CHANNELS*BITS-1:0] buttons,
    output logic [CHANNELS*BITS-1:0] pressed,
    output logic [CHANNELS*BITS-1:0] released,
    output logic                     frame_valid
);
    localparam int N = CHANNELS * BITS;
    localparam int PW = $clog2(POLL_PERIOD);
    localparam logic [PW-1:0] PER_MAX = PW'(POLL_PERIOD - 1);
    logic [PW-1:0] per;
    logic pending, idle, done, start, wrap;
    logic [N-1:0] raw, new_btn, held;
    assign start = idle && (poll_req || pending);
    assign wrap = auto_en && per == PER_MAX;
    assign new_btn = (ACTIVE_LOW != 0) ? ~raw : raw;
    serial_pad_phy #(.BITS(BITS), .CHANNELS(CHANNELS), .CLK_DIV(CLK_DIV)) u_phy (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .idle(idle),
        .latch(latch), .pulse(pulse), .busy(busy), .done(done), .frame(raw)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            per     <= '0;
            pending <= 1'b0;
            held    <= '0;
        end else begin
            per     <= (!auto_en || wrap) ? '0 : per + 1'b1;
            pending <= wrap || (pending && !start);
            if (done) held <= new_btn;
        end
    end
    // the fresh frame is presented in the done cycle itself, then held
    always_comb begin
        buttons     = done ? new_btn : held;
        pressed     = done ? new_btn & ~held : '0;
        released    = done ? ~new_btn & held : '0;
        frame_valid = done;
    end
endmodule

// File: tb/tb_serial_pad_poller.sv
// tb_serial_pad_poller: NES-style 2-pad instance and SNES-style 1-pad instance against behavioural pad models.
module tb_serial_pad_poller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] a_data;
    logic a_poll = 1'b0, a_auto = 1'b0;
    logic a_latch, a_pulse, a_busy, a_fv;
    logic [15:0] a_btn, a_prs, a_rel;
    logic [0:0] b_data;
    logic b_poll = 1'b0;
    logic b_latch, b_pulse, b_busy, b_fv;
    logic [15:0] b_btn, b_prs, b_rel;

    int checks = 0, errors = 0;
    logic [7:0] pad_a [2];
    logic [15:0] pad_b;
    logic [15:0] prev_a = '0, prev_b = '0;
    int idx_a = 0, idx_b = 0;

    serial_pad_poller #(.BITS(8), .CHANNELS(2), .CLK_DIV(4), .POLL_PERIOD(100), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(a_data), .poll_req(a_poll), .auto_en(a_auto),
        .latch(a_latch), .pulse(a_pulse), .busy(a_busy), .buttons(a_btn),
        .pressed(a_prs), .released(a_rel), .frame_valid(a_fv)
    );
    serial_pad_poller #(.BITS(16), .CHANNELS(1), .CLK_DIV(4), .POLL_PERIOD(200), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_data), .poll_req(b_poll), .auto_en(1'b0),
        .latch(b_latch), .pulse(b_pulse), .busy(b_busy), .buttons(b_btn),
        .pressed(b_prs), .released(b_rel), .frame_valid(b_fv)
    );

    // shift-register pad: latch reloads to bit 0, each pulse rising edge advances one bit
    always @(posedge a_latch or posedge a_pulse) idx_a = a_latch ? 0 : idx_a + 1;
    always @(posedge b_latch or posedge b_pulse) idx_b = b_latch ? 0 : idx_b + 1;
    assign a_data[0] = (idx_a < 8) ? ~pad_a[0][idx_a] : 1'b1;
    assign a_data[1] = (idx_a < 8) ? ~pad_a[1][idx_a] : 1'b1;
    assign b_data[0] = (idx_b < 16) ? pad_b[idx_b] : 1'b0;

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_latch, a_pulse, a_busy, a_fv} !== 4'b0 || a_btn !== 16'h0 || a_prs !== 16'h0 || a_rel !== 16'h0) begin
            errors++;
            $display("FAIL reset_a: latch/pulse/busy/fv=%b btn=%h prs=%h rel=%h, want all zero",
                     {a_latch, a_pulse, a_busy, a_fv}, a_btn, a_prs, a_rel);
        end
        checks++;
        if ({b_latch, b_pulse, b_busy, b_fv} !== 4'b0 || b_btn !== 16'h0 || b_prs !== 16'h0 || b_rel !== 16'h0) begin
            errors++;
            $display("FAIL reset_b: latch/pulse/busy/fv=%b btn=%h prs=%h rel=%h, want all zero",
                     {b_latch, b_pulse, b_busy, b_fv}, b_btn, b_prs, b_rel);
        end
        reset = 1'b0;
    endtask

    task automatic test_poll_a(input string tag);
        logic [15:0] exp;
        int lat = -1;
        exp = {pad_a[1], pad_a[0]};
        @(posedge clk);
        #1 a_poll = 1'b1;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(posedge clk);
            #1 a_poll = 1'b0;
            if (a_fv === 1'b1) begin
                lat = n;
                checks++;
                if (a_btn !== exp || a_prs !== (exp & ~prev_a) || a_rel !== (~exp & prev_a)) begin
                    errors++;
                    $display("FAIL %s frame: btn=%h prs=%h rel=%h, want %h %h %h",
                             tag, a_btn, a_prs, a_rel, exp, exp & ~prev_a, ~exp & prev_a);
                end
            end
        end
        checks++;
        if (lat != 65) begin
            errors++;
            $display("FAIL %s latency: got %0d, want 65", tag, lat);
        end
        prev_a = exp;
    endtask

    task automatic test_timing();
        int lat_err = 0, pul_err = 0, busy_err = 0, fv_at = -1;
        logic exp_pul;
        logic [15:0] exp;
        pad_a[0] = 8'h09;
        pad_a[1] = 8'h80;
        exp = {pad_a[1], pad_a[0]};
        @(posedge clk);
        #1 a_poll = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1 a_poll = 1'b0;
            exp_pul = 1'b0;
            for (int k = 1; k <= 7; k++) if (n >= 8*k + 1 && n <= 8*k + 4) exp_pul = 1'b1;
            if (a_latch !== (n <= 8)) lat_err++;
            if (a_pulse !== exp_pul) pul_err++;
            if (a_busy !== (n <= 64)) busy_err++;
            if (a_fv === 1'b1) begin
                if (fv_at < 0) fv_at = n;
                checks++;
                if (a_btn !== exp || a_prs !== exp || a_rel !== 16'h0) begin
                    errors++;
                    $display("FAIL first_frame: btn=%h prs=%h rel=%h, want %h %h 0000", a_btn, a_prs, a_rel, exp, exp);
                end
            end
            if (n == 66) begin
                checks++;
                if (a_btn !== exp || a_prs !== 16'h0 || a_rel !== 16'h0) begin
                    errors++;
                    $display("FAIL after_frame: btn=%h prs=%h rel=%h, want %h 0000 0000", a_btn, a_prs, a_rel, exp);
                end
            end
        end
        checks++;
        if (lat_err != 0) begin errors++; $display("FAIL latch_wave: %0d bad cycles, want 0", lat_err); end
        checks++;
        if (pul_err != 0) begin errors++; $display("FAIL pulse_wave: %0d bad cycles, want 0", pul_err); end
        checks++;
        if (busy_err != 0) begin errors++; $display("FAIL busy_wave: %0d bad cycles, want 0", busy_err); end
        checks++;
        if (fv_at != 65) begin errors++; $display("FAIL fv_time: got T+%0d, want T+65", fv_at); end
        prev_a = exp;
    endtask

    task automatic test_edges();
        pad_a[0] = 8'h0A;
        pad_a[1] = 8'h80;
        test_poll_a("edges");
        checks++;
        if (a_btn !== 16'h800A) begin errors++; $display("FAIL edges_held: btn=%h, want 800a", a_btn); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            pad_a[0] = 8'($urandom);
            pad_a[1] = 8'($urandom);
            test_poll_a($sformatf("random%0d", i));
        end
    endtask

    task automatic test_auto();
        int fv_t[$];
        int bad = 0, extra = 0;
        logic poked = 1'b0;
        a_auto = 1'b1;
        for (int t = 0; t < 500 && fv_t.size() < 4; t++) begin
            @(posedge clk);
            #1 a_poll = 1'b0;
            if (a_fv === 1'b1) begin
                fv_t.push_back(t);
                if (a_btn !== prev_a || a_prs !== 16'h0 || a_rel !== 16'h0) bad++;
            end
            if (a_busy === 1'b1 && !poked) begin
                a_poll = 1'b1;
                poked = 1'b1;
            end
        end
        a_auto = 1'b0;
        checks++;
        if (fv_t.size() != 4) begin
            errors++;
            $display("FAIL auto_count: got %0d frames, want 4", fv_t.size());
        end
        for (int i = 1; i < fv_t.size(); i++) begin
            checks++;
            if (fv_t[i] - fv_t[i-1] != 100) begin
                errors++;
                $display("FAIL auto_interval%0d: got %0d, want 100", i, fv_t[i] - fv_t[i-1]);
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL auto_frames: %0d bad frames, want 0", bad); end
        repeat (300) begin
            @(posedge clk);
            #1;
            if (a_fv !== 1'b0 || a_busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL auto_off: %0d active cycles, want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int extra = 0;
        pad_a[0] = 8'($urandom);
        pad_a[1] = 8'($urandom);
        @(posedge clk);
        #1 a_poll = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            @(posedge clk);
            #1 a_poll = 1'b0;
            if (n == 30) reset = 1'b1;
            if (n == 31) begin
                reset = 1'b0;
                checks++;
                if ({a_latch, a_pulse, a_busy, a_fv} !== 4'b0 || a_btn !== 16'h0) begin
                    errors++;
                    $display("FAIL mid_reset: latch/pulse/busy/fv=%b btn=%h, want 0000 0000",
                             {a_latch, a_pulse, a_busy, a_fv}, a_btn);
                end
            end
        end
        prev_a = '0;
        prev_b = '0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (a_fv !== 1'b0 || a_btn !== 16'h0 || a_busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL mid_reset_quiet: %0d active cycles, want 0", extra); end
        test_poll_a("after_reset");
    endtask

    task automatic test_snes();
        for (int i = 0; i < 2; i++) begin
            int lat = -1;
            pad_b = (i == 0) ? 16'hA5C3 : 16'($urandom);
            @(posedge clk);
            #1 b_poll = 1'b1;
            for (int n = 1; n <= 200 && lat < 0; n++) begin
                @(posedge clk);
                #1 b_poll = 1'b0;
                if (b_fv === 1'b1) begin
                    lat = n;
                    checks++;
                    if (b_btn !== pad_b || b_prs !== (pad_b & ~prev_b) || b_rel !== (~pad_b & prev_b)) begin
                        errors++;
                        $display("FAIL snes%0d frame: btn=%h prs=%h rel=%h, want %h %h %h",
                                 i, b_btn, b_prs, b_rel, pad_b, pad_b & ~prev_b, ~pad_b & prev_b);
                    end
                end
            end
            checks++;
            if (lat != 129) begin errors++; $display("FAIL snes%0d latency: got %0d, want 129", i, lat); end
            prev_b = pad_b;
        end
    endtask

    initial begin
        pad_a[0] = 8'h00;
        pad_a[1] = 8'h00;
        pad_b = 16'h0000;
        test_reset();
        test_timing();
        test_edges();
        test_random();
        test_auto();
        test_reset_mid();
        test_snes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
